// File: rtl/acc_8in.sv
// acc_8in: frame accumulator behind the eight-input adder tree.
// Beats are summed into a saturating W_A-bit accumulator. A beat tagged
// last closes the frame. The total, the beat count and the overflow flag
// are then held on a valid/ready output until they are consumed.
module acc_8in #(
  parameter int P_WIDTH = 6,
  parameter int P_GUARD = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [2*P_WIDTH+3-1:0]     i_s,
  input  logic                       i_valid,
  input  logic                       i_last,
  output logic                       o_ready,
  output logic [2*P_WIDTH+3+P_GUARD-1:0] o_acc,
  output logic [P_GUARD:0]           o_beats,
  output logic                       o_ovf,
  output logic                       o_valid,
  input  logic                       i_ready
);

  localparam int W_S = 2*P_WIDTH+3;
  localparam int W_A = W_S + P_GUARD;
  localparam int W_C = P_GUARD + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [W_A-1:0] acc_q, acc_d;
  logic [W_C-1:0] cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic [W_A-1:0] out_acc_q, out_acc_d;
  logic [W_C-1:0] out_beats_q, out_beats_d;
  logic           out_ovf_q, out_ovf_d;
  logic           out_valid_q, out_valid_d;

  logic           beat_s;
  logic           first_s;
  logic [W_A:0]   sum_s;
  logic [W_A-1:0] acc_nx_s;
  logic [W_C-1:0] cnt_nx_s;
  logic           ovf_nx_s;

  // A held result blocks new beats only until it is consumed in the same cycle.
  assign o_ready = ~i_rst & ((state_q != S_HOLD) | i_ready);
  assign beat_s  = i_valid & o_ready;
  // Any beat taken outside an open frame starts a new one.
  assign first_s = (state_q != S_ACC);
  assign sum_s   = {1'b0, acc_q} + {{(P_GUARD+1){1'b0}}, i_s};

  assign o_acc   = out_acc_q;
  assign o_beats = out_beats_q;
  assign o_ovf   = out_ovf_q;
  assign o_valid = out_valid_q;

  // Frame value after adding the incoming beat (saturating sum and count).
  always_comb begin
    acc_nx_s = '0;
    cnt_nx_s = '0;
    ovf_nx_s = 1'b0;
    if (first_s) begin
      acc_nx_s = {{P_GUARD{1'b0}}, i_s};
      cnt_nx_s = {{P_GUARD{1'b0}}, 1'b1};
      ovf_nx_s = 1'b0;
    end else begin
      if (sum_s[W_A]) begin
        acc_nx_s = '1;
        ovf_nx_s = 1'b1;
      end else begin
        acc_nx_s = sum_s[W_A-1:0];
        ovf_nx_s = ovf_q;
      end
      if (cnt_q == {W_C{1'b1}}) begin
        cnt_nx_s = cnt_q;
      end else begin
        cnt_nx_s = cnt_q + {{P_GUARD{1'b0}}, 1'b1};
      end
    end
  end

  // Next-state and next-output selection.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_acc_d   = out_acc_q;
    out_beats_d = out_beats_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;
    if (beat_s) begin
      if (i_last) begin
        // Close the frame: publish the result and clear the running state.
        state_d     = S_HOLD;
        out_acc_d   = acc_nx_s;
        out_beats_d = cnt_nx_s;
        out_ovf_d   = ovf_nx_s;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
      end else begin
        state_d     = S_ACC;
        acc_d       = acc_nx_s;
        cnt_d       = cnt_nx_s;
        ovf_d       = ovf_nx_s;
        out_valid_d = 1'b0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_ACC: begin
          state_d = S_ACC;
        end
        S_HOLD: begin
          if (i_ready) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
          end else begin
            state_d = S_HOLD;
          end
        end
        default: begin
          state_d     = S_IDLE;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_acc_q   <= '0;
      out_beats_q <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_acc_q   <= out_acc_d;
      out_beats_q <= out_beats_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_acc_8in.sv
// Directed bench for acc_8in with hand-computed expected results.
module tb_acc_8in;

  logic        clk;
  logic        rst;
  logic [14:0] s;
  logic        valid;
  logic        last;
  logic        ready_o;
  logic [18:0] acc;
  logic [4:0]  beats;
  logic        ovf;
  logic        valid_o;
  logic        ready_i;

  int n_tests;
  int n_fail;

  acc_8in #(.P_WIDTH(6), .P_GUARD(4)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_s     (s),
    .i_valid (valid),
    .i_last  (last),
    .o_ready (ready_o),
    .o_acc   (acc),
    .o_beats (beats),
    .o_ovf   (ovf),
    .o_valid (valid_o),
    .i_ready (ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [14:0] d, input logic l);
    valid = v;
    s     = d;
    last  = l;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; ready_i = 1'b1;
    drive(1'b1, 15'd123, 1'b1);

    // Reset held two cycles with valid beats offered
    tick(); tick();
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_acc",   {13'd0, acc}, 32'd0);
    chk("rst_beats", {27'd0, beats}, 32'd0);
    chk("rst_ovf",   {31'd0, ovf}, 32'd0);
    chk("rst_ready", {31'd0, ready_o}, 32'd0);
    rst = 1'b0;
    drive(1'b0, 15'd0, 1'b0);
    tick();
    chk("ready_after_rst", {31'd0, ready_o}, 32'd1);
    chk("idle_valid", {31'd0, valid_o}, 32'd0);

    // Frame of four beats
    drive(1'b1, 15'd100, 1'b0); tick();
    drive(1'b1, 15'd200, 1'b0); tick();
    drive(1'b1, 15'd300, 1'b0); tick();
    chk("f4_not_yet", {31'd0, valid_o}, 32'd0);
    drive(1'b1, 15'd400, 1'b1); tick();
    chk("f4_valid", {31'd0, valid_o}, 32'd1);
    chk("f4_acc",   {13'd0, acc}, 32'd1000);
    chk("f4_beats", {27'd0, beats}, 32'd4);
    chk("f4_ovf",   {31'd0, ovf}, 32'd0);
    drive(1'b0, 15'd0, 1'b0); tick();
    chk("f4_one_cycle", {31'd0, valid_o}, 32'd0);

    // Back-to-back single-beat frames
    drive(1'b1, 15'd32760, 1'b1); tick();
    chk("b2b1_valid", {31'd0, valid_o}, 32'd1);
    chk("b2b1_acc",   {13'd0, acc}, 32'd32760);
    chk("b2b1_beats", {27'd0, beats}, 32'd1);
    drive(1'b1, 15'd7, 1'b1);
    chk("b2b_ready", {31'd0, ready_o}, 32'd1);
    tick();
    chk("b2b2_valid", {31'd0, valid_o}, 32'd1);
    chk("b2b2_acc",   {13'd0, acc}, 32'd7);
    chk("b2b2_beats", {27'd0, beats}, 32'd1);
    drive(1'b0, 15'd0, 1'b0); tick();
    chk("b2b_drop", {31'd0, valid_o}, 32'd0);

    // Backpressure while a result is held
    drive(1'b1, 15'd10, 1'b0); tick();
    drive(1'b1, 15'd20, 1'b1); tick();
    ready_i = 1'b0;
    drive(1'b1, 15'd99, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ready", {31'd0, ready_o}, 32'd0);
      tick();
      chk("bp_acc",   {13'd0, acc}, 32'd30);
      chk("bp_beats", {27'd0, beats}, 32'd2);
      chk("bp_valid", {31'd0, valid_o}, 32'd1);
    end
    ready_i = 1'b1;
    drive(1'b1, 15'd5, 1'b1);
    #1;
    chk("bp_release_ready", {31'd0, ready_o}, 32'd1);
    tick();
    chk("bp_new_acc",   {13'd0, acc}, 32'd5);
    chk("bp_new_beats", {27'd0, beats}, 32'd1);
    chk("bp_new_valid", {31'd0, valid_o}, 32'd1);
    drive(1'b0, 15'd0, 1'b0); tick();

    // Saturation: 20 x 32760 exceeds 2^19-1
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 15'd32760, (i == 19) ? 1'b1 : 1'b0);
      tick();
    end
    chk("sat_acc",   {13'd0, acc}, 32'd524287);
    chk("sat_ovf",   {31'd0, ovf}, 32'd1);
    chk("sat_beats", {27'd0, beats}, 32'd20);
    drive(1'b1, 15'd1, 1'b1); tick();
    chk("post_sat_acc", {13'd0, acc}, 32'd1);
    chk("post_sat_ovf", {31'd0, ovf}, 32'd0);
    drive(1'b0, 15'd0, 1'b0); tick();

    // Beat count saturates at 31: 33 beats of 1, with idle gaps ignored
    for (int i = 0; i < 33; i++) begin
      drive(1'b1, 15'd1, (i == 32) ? 1'b1 : 1'b0);
      tick();
      if (i == 10) begin
        drive(1'b0, 15'd500, 1'b1); tick(); tick();
      end
    end
    chk("cnt_sat_beats", {27'd0, beats}, 32'd31);
    chk("cnt_sat_acc",   {13'd0, acc}, 32'd33);
    chk("cnt_sat_ovf",   {31'd0, ovf}, 32'd0);

    // Consume held result with a non-last beat: that beat opens a new frame
    drive(1'b1, 15'd3, 1'b0); tick();
    chk("hold_to_acc_valid", {31'd0, valid_o}, 32'd0);
    drive(1'b1, 15'd4, 1'b1); tick();
    chk("hold_to_acc_acc",   {13'd0, acc}, 32'd7);
    chk("hold_to_acc_beats", {27'd0, beats}, 32'd2);
    drive(1'b0, 15'd0, 1'b0); tick();

    // Reset in the middle of a frame discards it
    drive(1'b1, 15'd50, 1'b0); tick();
    drive(1'b1, 15'd60, 1'b0); tick();
    drive(1'b1, 15'd70, 1'b0); tick();
    rst = 1'b1;
    drive(1'b0, 15'd0, 1'b0); tick();
    chk("midrst_valid", {31'd0, valid_o}, 32'd0);
    rst = 1'b0;
    drive(1'b1, 15'd5, 1'b0); tick();
    drive(1'b1, 15'd6, 1'b1); tick();
    chk("midrst_acc",   {13'd0, acc}, 32'd11);
    chk("midrst_beats", {27'd0, beats}, 32'd2);
    chk("midrst_valid2", {31'd0, valid_o}, 32'd1);
    drive(1'b0, 15'd0, 1'b0); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
